gpu_command_decoder: RTL and testbench

GPU_COMMAND_DECODER -- requirements
Module: gpu_command_decoder

---
 rtl/gpu_pkg.sv | 25 ++
 rtl/gpu_command_decoder.sv | 187 ++++++++++++++++++
 tb/tb_gpu_command_decoder.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command path: opcodes, packet lengths, coordinate widths
// and the decoder FSM state encoding.
package gpu_pkg;

    localparam logic [7:0] OP_FILL = 8'h01;
    localparam logic [7:0] OP_BLIT = 8'h02;

    localparam int FILL_LEN = 8;
    localparam int BLIT_LEN = 10;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    // Wide enough to index every byte of the longest packet.
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARGS,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/gpu_command_decoder.sv
// Byte-stream decoder that assembles FILL/BLIT packets and hands them to the raster engine.
// Optional: define GPU_CMD_RANGE_CHECK_EN to reject inverted or out-of-bounds rectangles before issue.
module gpu_command_decoder
    import gpu_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic [X_W-1:0] X1,
    output logic [X_W-1:0] X2,
    output logic [Y_W-1:0] Y1,
    output logic [Y_W-1:0] Y2,
    output logic [X_W-1:0] blit_x_width,
    output logic [Y_W-1:0] blit_y_height,
    output logic           fill_value,
    output logic           start_fill,
    output logic           start_blit,
    input  logic           busy,
    input  logic           error,
    output logic           cmd_error,
    output logic [7:0]     cmd_count
);

    localparam logic [1:0] ACK_LIMIT = 2'd2;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] arg_idx;
    logic [IDX_W-1:0] last_idx;
    logic             is_blit;
    logic [1:0]       ack_wait;
    logic             accept;
    logic             opcode_ok;
    logic             last_arg;
    logic             range_fail;

    assign accept    = rx_valid && rx_ready;
    assign opcode_ok = (rx_data == OP_FILL) || (rx_data == OP_BLIT);
    assign last_idx  = is_blit ? IDX_W'(BLIT_LEN - 1) : IDX_W'(FILL_LEN - 1);
    assign last_arg  = (state == ARGS) && accept && (arg_idx == last_idx);

    // Held low while in reset so the source cannot hand over a byte that would be lost.
    assign rx_ready = rst_n && ((state == IDLE) || (state == ARGS));

    // Every coordinate byte precedes the final argument byte, so the stored fields are complete here.
`ifdef GPU_CMD_RANGE_CHECK_EN
    assign range_fail = (X1 > X2) || (Y1 > Y2)
                     || (int'(X1) > WIDTH)  || (int'(X2) > WIDTH)
                     || (int'(Y1) > HEIGHT) || (int'(Y2) > HEIGHT);
`else
    logic unused_dims;
    assign unused_dims = ^{WIDTH, HEIGHT};
    assign range_fail  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept && opcode_ok) begin
                    state_next = ARGS;
                end
            end
            ARGS: begin
                if (last_arg) begin
                    state_next = range_fail ? IDLE : ISSUE;
                end
            end
            ISSUE: begin
                if (!busy) begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_next = WAIT_DONE;
                end else if (error || (ack_wait == ACK_LIMIT)) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand fields are only written in ARGS, which keeps them frozen from issue until the next packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X1            <= '0;
            X2            <= '0;
            Y1            <= '0;
            Y2            <= '0;
            blit_x_width  <= '0;
            blit_y_height <= '0;
            fill_value    <= 1'b0;
            start_fill    <= 1'b0;
            start_blit    <= 1'b0;
            cmd_error     <= 1'b0;
            cmd_count     <= 8'd0;
            arg_idx       <= '0;
            is_blit       <= 1'b0;
            ack_wait      <= 2'd0;
        end else begin
            start_fill <= 1'b0;
            start_blit <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (opcode_ok) begin
                            cmd_error <= 1'b0;
                            is_blit   <= (rx_data == OP_BLIT);
                            arg_idx   <= IDX_W'(1);
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                end
                ARGS: begin
                    if (accept) begin
                        arg_idx <= arg_idx + IDX_W'(1);
                        case (arg_idx)
                            IDX_W'(1): X1[X_W-1]   <= rx_data[0];
                            IDX_W'(2): X1[X_W-2:0] <= rx_data;
                            IDX_W'(3): Y1          <= rx_data;
                            IDX_W'(4): X2[X_W-1]   <= rx_data[0];
                            IDX_W'(5): X2[X_W-2:0] <= rx_data;
                            IDX_W'(6): Y2          <= rx_data;
                            IDX_W'(7): begin
                                if (is_blit) begin
                                    blit_x_width[X_W-1] <= rx_data[0];
                                end else begin
                                    fill_value <= rx_data[0];
                                end
                            end
                            IDX_W'(8): blit_x_width[X_W-2:0] <= rx_data;
                            IDX_W'(9): blit_y_height         <= rx_data;
                            default: ;
                        endcase
                        if (last_arg && range_fail) begin
                            cmd_error <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!busy) begin
                        start_fill <= !is_blit;
                        start_blit <= is_blit;
                        ack_wait   <= 2'd0;
                    end
                end
                WAIT_ACK: begin
                    if (!busy) begin
                        if (error || (ack_wait == ACK_LIMIT)) begin
                            cmd_error <= 1'b1;
                        end else begin
                            ack_wait <= ack_wait + 2'd1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        cmd_count <= cmd_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_command_decoder.sv
// Self-checking bench for gpu_command_decoder: directed packets plus randomized traffic
// compared against a packet-level model of fields, start pulses, error flag and completion count.
module tb_gpu_command_decoder;
    import gpu_pkg::*;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 200;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [X_W-1:0] X1;
    logic [X_W-1:0] X2;
    logic [Y_W-1:0] Y1;
    logic [Y_W-1:0] Y2;
    logic [X_W-1:0] blit_x_width;
    logic [Y_W-1:0] blit_y_height;
    logic           fill_value;
    logic           start_fill;
    logic           start_blit;
    logic           busy;
    logic           error;
    logic           cmd_error;
    logic [7:0]     cmd_count;

    int tests = 0;
    int fails = 0;
    int n_fill = 0;
    int n_blit = 0;
    int exp_count = 0;
    logic [7:0] pkt[$];

    gpu_command_decoder #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .X1           (X1),
        .X2           (X2),
        .Y1           (Y1),
        .Y2           (Y2),
        .blit_x_width (blit_x_width),
        .blit_y_height(blit_y_height),
        .fill_value   (fill_value),
        .start_fill   (start_fill),
        .start_blit   (start_blit),
        .busy         (busy),
        .error        (error),
        .cmd_error    (cmd_error),
        .cmd_count    (cmd_count)
    );

    always #5 clk = ~clk;

    // A pulse longer than one cycle shows up as an extra count.
    always @(negedge clk) begin
        if (start_fill) n_fill++;
        if (start_blit) n_blit++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_byte_timeout: rx_ready=%0b required=1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_packet();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic build_packet(input logic blit_op, input logic [8:0] x1, input logic [7:0] y1,
                                input logic [8:0] x2, input logic [7:0] y2, input logic v,
                                input logic [8:0] w, input logic [7:0] h);
        pkt.delete();
        pkt.push_back(blit_op ? 8'h02 : 8'h01);
        pkt.push_back({7'($urandom), x1[8]});
        pkt.push_back(x1[7:0]);
        pkt.push_back(y1);
        pkt.push_back({7'($urandom), x2[8]});
        pkt.push_back(x2[7:0]);
        pkt.push_back(y2);
        if (blit_op) begin
            pkt.push_back({7'd0, w[8]});
            pkt.push_back(w[7:0]);
            pkt.push_back(h);
        end else begin
            pkt.push_back({7'($urandom), v});
        end
    endtask

    // which: 0 = no start seen, 1 = fill, 2 = blit, 3 = both at once.
    task automatic wait_start(output int which);
        which = 0;
        for (int i = 0; i < 8 && which == 0; i++) begin
            @(negedge clk);
            which = int'({start_blit, start_fill});
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        busy     = 1'b0;
        error    = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({X1, X2, Y1, Y2, blit_x_width, blit_y_height, fill_value, start_fill, start_blit,
             cmd_error, cmd_count} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got X1=%h X2=%h Y1=%h Y2=%h err=%b cnt=%h, required all 0",
                     X1, X2, Y1, Y2, cmd_error, cmd_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_rx_ready: got %b required 1", rx_ready);
        end
        tests++;
        if (cmd_count !== 8'd0 || cmd_error !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release_state: cnt=%0d err=%b required 0/0", cmd_count, cmd_error);
        end
        exp_count = 0;
    endtask

    task automatic test_fill();
        int which;
        int f0;
        f0  = n_fill;
        pkt = {8'h01, 8'h00, 8'h0A, 8'h05, 8'h00, 8'h14, 8'h0F, 8'h01};
        send_packet();
        wait_start(which);
        tests++;
        if (which !== 1) begin
            fails++;
            $display("[TB] FAIL fill_start: got %0d required 1", which);
        end
        tests++;
        if (X1 !== 9'd10 || Y1 !== 8'd5 || X2 !== 9'd20 || Y2 !== 8'd15) begin
            fails++;
            $display("[TB] FAIL fill_coords: got %0d,%0d,%0d,%0d required 10,5,20,15", X1, Y1, X2, Y2);
        end
        tests++;
        if (fill_value !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fill_value: got %b required 1", fill_value);
        end
        tests++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fill_rx_ready_busy: got %b required 0", rx_ready);
        end
        busy = 1'b1;
        repeat (3) @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        exp_count = 1;
        tests++;
        if (cmd_count !== 8'd1 || cmd_error !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fill_done: cnt=%0d err=%b required 1/0", cmd_count, cmd_error);
        end
        tests++;
        if (n_fill - f0 !== 1) begin
            fails++;
            $display("[TB] FAIL fill_pulse_width: got %0d pulse cycles required 1", n_fill - f0);
        end
    endtask

    task automatic test_blit();
        int which;
        pkt = {8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h03, 8'h02};
        send_packet();
        wait_start(which);
        tests++;
        if (which !== 2) begin
            fails++;
            $display("[TB] FAIL blit_start: got %0d required 2", which);
        end
        tests++;
        if (X1 !== 9'd0 || Y1 !== 8'd0 || X2 !== 9'd256 || Y2 !== 8'd10) begin
            fails++;
            $display("[TB] FAIL blit_coords: got %0d,%0d,%0d,%0d required 0,0,256,10", X1, Y1, X2, Y2);
        end
        tests++;
        if (blit_x_width !== 9'd3 || blit_y_height !== 8'd2) begin
            fails++;
            $display("[TB] FAIL blit_size: got %0dx%0d required 3x2", blit_x_width, blit_y_height);
        end
        busy = 1'b1;
        repeat (2) @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        exp_count++;
        tests++;
        if (cmd_count !== 8'(exp_count)) begin
            fails++;
            $display("[TB] FAIL blit_count: got %0d required %0d", cmd_count, exp_count);
        end
    endtask

    task automatic test_bad_opcode();
        int which;
        int f0;
        int b0;
        f0 = n_fill;
        b0 = n_blit;
        send_byte(8'h07);
        tests++;
        if (cmd_error !== 1'b1 || rx_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bad_opcode_flag: err=%b ready=%b required 1/1", cmd_error, rx_ready);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (n_fill !== f0 || n_blit !== b0) begin
            fails++;
            $display("[TB] FAIL bad_opcode_no_start: got %0d starts required 0", (n_fill - f0) + (n_blit - b0));
        end
        build_packet(1'b0, 9'd1, 8'd2, 9'd30, 8'd40, 1'b0, 9'd0, 8'd0);
        send_byte(pkt[0]);
        tests++;
        if (cmd_error !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bad_opcode_clear: got %b required 0", cmd_error);
        end
        for (int i = 1; i < pkt.size(); i++) send_byte(pkt[i]);
        wait_start(which);
        tests++;
        if (which !== 1 || fill_value !== 1'b0) begin
            fails++;
            $display("[TB] FAIL recover_fill: start=%0d v=%b required 1/0", which, fill_value);
        end
        busy = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        exp_count++;
    endtask

    task automatic test_busy_hold();
        int held_bad;
        held_bad = 0;
        busy = 1'b1;
        build_packet(1'b0, 9'd5, 8'd5, 9'd50, 8'd60, 1'b1, 9'd0, 8'd0);
        send_packet();
        repeat (3) begin
            @(negedge clk);
            if (rx_ready !== 1'b0 || start_fill !== 1'b0 || start_blit !== 1'b0) held_bad++;
        end
        tests++;
        if (held_bad != 0) begin
            fails++;
            $display("[TB] FAIL busy_hold: %0d cycles with ready/start high, required 0", held_bad);
        end
        busy = 1'b0;
        @(negedge clk);
        tests++;
        if (start_fill !== 1'b1) begin
            fails++;
            $display("[TB] FAIL busy_release_start: start_fill=%b required 1", start_fill);
        end
        busy = 1'b1;
        repeat (2) @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        exp_count++;
        tests++;
        if (cmd_count !== 8'(exp_count)) begin
            fails++;
            $display("[TB] FAIL busy_hold_count: got %0d required %0d", cmd_count, exp_count);
        end
    endtask

    task automatic test_range();
        int which;
        build_packet(1'b0, 9'd300, 8'd0, 9'd100, 8'd0, 1'b0, 9'd0, 8'd0);
        send_packet();
        wait_start(which);
`ifdef GPU_CMD_RANGE_CHECK_EN
        tests++;
        if (which !== 0 || cmd_error !== 1'b1) begin
            fails++;
            $display("[TB] FAIL range_reject: start=%0d err=%b required 0/1", which, cmd_error);
        end
`else
        tests++;
        if (which !== 1 || X1 !== 9'd300 || X2 !== 9'd100) begin
            fails++;
            $display("[TB] FAIL range_forward: start=%0d X1=%0d X2=%0d required 1/300/100", which, X1, X2);
        end
        error = 1'b1;
        @(negedge clk);
        error = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_error !== 1'b1) begin
            fails++;
            $display("[TB] FAIL engine_error: cmd_error=%b required 1", cmd_error);
        end
`endif
        tests++;
        if (cmd_count !== 8'(exp_count) || rx_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL range_after: cnt=%0d ready=%b required %0d/1", cmd_count, rx_ready, exp_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        int which;
        build_packet(1'b0, 9'd7, 8'd8, 9'd9, 8'd10, 1'b1, 9'd0, 8'd0);
        for (int i = 0; i < 4; i++) send_byte(pkt[i]);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (cmd_count !== 8'd0 || X1 !== 9'd0 || Y1 !== 8'd0 || cmd_error !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset: cnt=%0d X1=%0d Y1=%0d err=%b required 0", cmd_count, X1, Y1, cmd_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_count = 0;
        build_packet(1'b1, 9'd17, 8'd33, 9'd300, 8'd120, 1'b0, 9'd257, 8'd99);
        send_packet();
        wait_start(which);
        tests++;
        if (which !== 2) begin
            fails++;
            $display("[TB] FAIL reset_blit_start: got %0d required 2", which);
        end
        tests++;
        if (X1 !== 9'd17 || Y1 !== 8'd33 || X2 !== 9'd300 || Y2 !== 8'd120 ||
            blit_x_width !== 9'd257 || blit_y_height !== 8'd99) begin
            fails++;
            $display("[TB] FAIL reset_blit_fields: got %0d,%0d,%0d,%0d w%0d h%0d required 17,33,300,120 w257 h99",
                     X1, Y1, X2, Y2, blit_x_width, blit_y_height);
        end
        busy = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        exp_count = 1;
        tests++;
        if (cmd_count !== 8'd1) begin
            fails++;
            $display("[TB] FAIL reset_blit_count: got %0d required 1", cmd_count);
        end
    endtask

    // Random packets and engine behaviour until the completion count reaches 255, then one more wraps it.
    task automatic test_random_traffic();
        int which;
        int exp_which;
        int mode;
        int iter;
        logic blit_op;
        logic v;
        logic [8:0] x1, x2, w;
        logic [7:0] y1, y2, h;
        logic bad;
        logic exp_err;
        iter = 0;
        while (exp_count != 255 && iter < 900) begin
            iter++;
            blit_op = 1'($urandom);
            v       = 1'($urandom);
            w       = 9'($urandom);
            h       = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                x1 = 9'($urandom); x2 = 9'($urandom);
                y1 = 8'($urandom); y2 = 8'($urandom);
            end else begin
                x1 = 9'($urandom_range(0, WIDTH));
                x2 = 9'($urandom_range(int'(x1), WIDTH));
                y1 = 8'($urandom_range(0, HEIGHT));
                y2 = 8'($urandom_range(int'(y1), HEIGHT));
            end
`ifdef GPU_CMD_RANGE_CHECK_EN
            bad = (x1 > x2) || (y1 > y2) || (int'(x1) > WIDTH) || (int'(x2) > WIDTH) ||
                  (int'(y1) > HEIGHT) || (int'(y2) > HEIGHT);
`else
            bad = 1'b0;
`endif
            mode = $urandom_range(0, 9);
            build_packet(blit_op, x1, y1, x2, y2, v, w, h);
            send_packet();
            wait_start(which);
            exp_which = bad ? 0 : (blit_op ? 2 : 1);
            tests++;
            if (which !== exp_which) begin
                fails++;
                $display("[TB] FAIL rand_start[%0d]: got %0d required %0d", iter, which, exp_which);
            end
            if (bad) begin
                exp_err = 1'b1;
            end else begin
                tests++;
                if (X1 !== x1 || Y1 !== y1 || X2 !== x2 || Y2 !== y2) begin
                    fails++;
                    $display("[TB] FAIL rand_coords[%0d]: got %0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d",
                             iter, X1, Y1, X2, Y2, x1, y1, x2, y2);
                end
                tests++;
                if (blit_op ? (blit_x_width !== w || blit_y_height !== h) : (fill_value !== v)) begin
                    fails++;
                    $display("[TB] FAIL rand_operand[%0d]: got w%0d h%0d v%b required w%0d h%0d v%b",
                             iter, blit_x_width, blit_y_height, fill_value, w, h, v);
                end
                if (mode == 0) begin
                    error = 1'b1;
                    @(negedge clk);
                    error = 1'b0;
                    exp_err = 1'b1;
                end else if (mode == 1) begin
                    repeat (4) @(negedge clk);
                    exp_err = 1'b1;
                end else begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    busy = 1'b1;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    busy = 1'b0;
                    exp_count = (exp_count + 1) % 256;
                    exp_err   = 1'b0;
                end
            end
            repeat (2) @(negedge clk);
            tests++;
            if (cmd_count !== 8'(exp_count) || cmd_error !== exp_err || rx_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL rand_result[%0d]: cnt=%0d err=%b ready=%b required %0d/%b/1",
                         iter, cmd_count, cmd_error, rx_ready, exp_count, exp_err);
            end
        end
        tests++;
        if (cmd_count !== 8'd255) begin
            fails++;
            $display("[TB] FAIL count_at_255: got %0d required 255", cmd_count);
        end
        build_packet(1'b0, 9'd0, 8'd0, 9'd1, 8'd1, 1'b1, 9'd0, 8'd0);
        send_packet();
        wait_start(which);
        busy = 1'b1;
        repeat (2) @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (cmd_count !== 8'd0) begin
            fails++;
            $display("[TB] FAIL count_wrap: got %0d required 0", cmd_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_blit();
        test_bad_opcode();
        test_busy_hold();
        test_range();
        test_reset_mid_packet();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
